// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state types and default UART bit timing for uart_loader.
//            UART_LOADER_CSUM_EN adds the checksum state.
// Revision : 1.0
// ============================================================================
package loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
`ifdef UART_LOADER_CSUM_EN
    S_CSUM = 3'd2,
`endif
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART byte receiver with input synchronizer, mid-bit sampling,
//            start-glitch rejection and stop-bit framing check.
// Revision : 1.0
// ============================================================================
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Synchronizer and edge-history flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader
// Brief    : Loads a length-prefixed little-endian word stream from UART into
//            a BRAM port. UART_LOADER_CSUM_EN enables the trailing XOR check.
// Revision : 1.0
// ============================================================================
module uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              wea,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  logic              byte_valid;
  logic              frame_err;
  logic [7:0]        rx_byte;

  loader_state_e     state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;
  logic [31:0]       dina_q, dina_d;
  logic              wea_q, wea_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       word_w;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (rx_byte),
    .frame_err (frame_err)
  );

  // The incoming byte is the most significant of the word being completed.
  assign word_w = {rx_byte, shift_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addra_q    <= '0;
      last_idx_q <= '0;
      dina_q     <= '0;
      wea_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addra_q    <= addra_d;
      last_idx_q <= last_idx_d;
      dina_q     <= dina_d;
      wea_q      <= wea_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef UART_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addra_d    = addra_q;
    last_idx_d = last_idx_q;
    dina_d     = dina_q;
    wea_d      = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
`ifdef UART_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    if (wea_q) addra_d = addra_q + ADDR_W'(1);

    case (state_q)
      S_LEN: begin
        if (frame_err) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {rx_byte, shift_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            // N-1 always fits ADDR_W bits once N <= 2**ADDR_W is checked.
            last_idx_d = word_w[ADDR_W-1:0] - ADDR_W'(1);
            if ({1'b0, word_w} > MAX_WORDS) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else if (word_w == 32'd0) begin
`ifdef UART_LOADER_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (frame_err) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {rx_byte, shift_q[23:8]};
`ifdef UART_LOADER_CSUM_EN
          csum_d     = csum_q ^ rx_byte;
`endif
          if (byte_cnt_q == 2'd3) begin
            wea_d  = 1'b1;
            dina_d = word_w;
          end
        end else if (wea_q && (addra_q == last_idx_q)) begin
`ifdef UART_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef UART_LOADER_CSUM_EN
      S_CSUM: begin
        if (frame_err) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (byte_valid) begin
          if (rx_byte == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_DONE: ;
      S_ERR:  ;
      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  assign addra = addra_q;
  assign dina  = dina_q;
  assign wea   = wea_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader
// Brief    : Scoreboard bench for uart_loader with serial stimulus and a
//            word-level reference model. Honors UART_LOADER_CSUM_EN.
// Revision : 1.0
// ============================================================================
module tb_uart_loader;

  localparam int CPB = 16;
  localparam int AW  = 20;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          rxd  = 1'b1;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic          wea, done, err;

  int          total = 0;
  int          bad   = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] words[$];

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rxd  (rxd),
    .addra(addra),
    .dina (dina),
    .wea  (wea),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge clk) begin
    if (rstn && wea) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addra=%0h dina=%h, required no write", addra, dina);
      end else begin
        mon_e = exp_q.pop_front();
        if (addra !== mon_e.a || dina !== mon_e.d) begin
          bad++;
          $display("FAIL write: got addra=%0h dina=%h, required addra=%0h dina=%h",
                   addra, dina, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Length, then the contents of 'words'; expected writes are word index/value.
  task automatic send_stream(input logic csum_ok);
    logic [7:0] x;
    x = 8'h00;
    send_word(32'(words.size()));
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back('{a: AW'(i), d: words[i]});
      for (int k = 0; k < 4; k++) x = x ^ words[i][8*k +: 8];
      send_word(words[i]);
    end
`ifdef UART_LOADER_CSUM_EN
    send_byte(csum_ok ? x : ~x, 1'b1);
`else
    if (!csum_ok) x = ~x;
`endif
  endtask

  task automatic finish_check(input string name, input logic exp_done, input logic exp_err);
    repeat (20) @(posedge clk);
    #1;
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_addra", 32'(addra), 32'd0);
    check("rst_dina", dina, 32'd0);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // Reference stream
    words = '{32'h12345678, 32'hDEADBEEF};
    send_stream(1'b1);
    finish_check("basic", 1'b1, 1'b0);

`ifdef UART_LOADER_CSUM_EN
    do_reset();
    words = '{32'h12345678, 32'hDEADBEEF};
    send_stream(1'b0);
    finish_check("bad_csum", 1'b0, 1'b1);
`endif

    // Start-bit glitch, then a normal load
    do_reset();
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("glitch_err", 32'(err), 32'd0);
    check("glitch_done", 32'(done), 32'd0);
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    send_stream(1'b1);
    finish_check("after_glitch", 1'b1, 1'b0);

    // Zero-length program
    do_reset();
    words.delete();
    send_stream(1'b1);
    finish_check("zero_len", 1'b1, 1'b0);

    // Oversize length; later bytes must not write
    do_reset();
    send_word(32'h0010_0001);
    send_word(32'hCAFEF00D);
    finish_check("oversize", 1'b0, 1'b1);

    // Framing error mid-data; later valid bytes must not write
    do_reset();
    send_word(32'd2);
    exp_q.push_back('{a: AW'(0), d: 32'hA5A55A5A});
    send_word(32'hA5A55A5A);
    send_byte(8'h3C, 1'b0);
    send_word(32'h01020304);
    finish_check("frame_err", 1'b0, 1'b1);

    // Reset mid-word discards the partial word
    do_reset();
    send_word(32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    do_reset();
    words = '{$urandom, $urandom};
    send_stream(1'b1);
    finish_check("after_mid_reset", 1'b1, 1'b0);

    // Randomized loads
    for (int it = 0; it < 3; it++) begin
      do_reset();
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) words.push_back($urandom);
      send_stream(1'b1);
      finish_check("random", 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
